// File: rtl/divmmc_spi_pkg.sv
// Shared constants for the DivMMC SD-card SPI responder: default port
// addresses, idle byte value and the byte-engine state encoding.
package divmmc_spi_pkg;

  localparam logic [7:0] PORT_CS_DEF   = 8'hE7;
  localparam logic [7:0] PORT_DATA_DEF = 8'hEB;
  localparam logic [7:0] BYTE_RST      = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  // Divider needs at least one bit even when DIV is 0.
  function automatic int div_width(input int div);
    return (div < 1) ? 1 : $clog2(div + 1);
  endfunction

endpackage

// File: rtl/divmmc_spi_byte_shifter.sv
// Mode-0 SPI byte engine: one MSB-first 8-bit exchange per start pulse,
// each clock half-period lasting DIV+1 ce ticks.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | no exchange; ck=0, mosi=1
//   LOW     | ck low, mosi holds current bit; ends by raising ck
//   HIGH    | ck high, miso already sampled; ends by lowering ck
module divmmc_spi_byte_shifter
  import divmmc_spi_pkg::*;
#(
  parameter int DIV = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic       ck,
  output logic       mosi
);

  localparam int            DW      = div_width(DIV);
  localparam logic [DW-1:0] DIV_END = DW'(DIV);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          ck_q, ck_d;
  logic          mosi_q, mosi_d;
  logic          phase_end;

  assign phase_end = (div_q == DIV_END);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ck_d    = ck_q;
    mosi_d  = mosi_q;
    done    = 1'b0;
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_d = tx;
            mosi_d  = tx[7];
            ck_d    = 1'b0;
            cnt_d   = 3'd0;
            div_d   = '0;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            ck_d    = 1'b1;
            shift_d = {shift_q[6:0], miso};
            div_d   = '0;
            state_d = ST_HIGH;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            ck_d  = 1'b0;
            div_d = '0;
            if (cnt_q == 3'd7) begin
              mosi_d  = 1'b1;
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // shift_q[7] is already the next bit: the shift happened at LOW end.
              cnt_d   = cnt_q + 3'd1;
              mosi_d  = shift_q[7];
              state_d = ST_LOW;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= 3'd0;
      shift_q <= BYTE_RST;
      ck_q    <= 1'b0;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ck_q    <= ck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign rx   = shift_q;
  assign ck   = ck_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/divmmc_spi.sv
// DivMMC SD-card responder: decodes Z80 I/O on the chip-select and data
// ports, holds the card selects and last received byte, drives the SPI engine.
module divmmc_spi
  import divmmc_spi_pkg::*;
#(
  parameter int         DIV       = 0,
  parameter logic [7:0] PORT_CS   = PORT_CS_DEF,
  parameter logic [7:0] PORT_DATA = PORT_DATA_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        oe,
  output logic        busy,
  output logic [1:0]  cs,
  output logic        ck,
  output logic        mosi,
  input  logic        miso
);

  logic       io_cs, io_dt, acc, acc_edge;
  logic       accd_q, accd_d;
  logic [1:0] cs_q, cs_d;
  logic [7:0] q_q, q_d;
  logic       start, done;
  logic [7:0] tx, rx;
  logic       unused_a_hi;

  assign unused_a_hi = ^a[15:8];

  assign io_cs    = !iorq && (a[7:0] == PORT_CS);
  assign io_dt    = !iorq && (a[7:0] == PORT_DATA);
  assign oe       = io_dt && !rd;
  assign acc      = (io_cs || io_dt) && (!rd || !wr);
  // Act once per I/O cycle no matter how many wait-state ce ticks it spans.
  assign acc_edge = acc && !accd_q;

  assign start = ce && acc_edge && io_dt && !busy;
  assign tx    = !wr ? d : BYTE_RST;

  always_comb begin
    accd_d = accd_q;
    cs_d   = cs_q;
    q_d    = q_q;
    if (ce) begin
      accd_d = acc;
      if (acc_edge && io_cs && !wr) cs_d = d[1:0];
    end
    if (done) q_d = rx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accd_q <= 1'b0;
      cs_q   <= 2'b11;
      q_q    <= BYTE_RST;
    end else begin
      accd_q <= accd_d;
      cs_q   <= cs_d;
      q_q    <= q_d;
    end
  end

  divmmc_spi_byte_shifter #(.DIV(DIV)) u_shifter (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .tx    (tx),
    .miso  (miso),
    .busy  (busy),
    .done  (done),
    .rx    (rx),
    .ck    (ck),
    .mosi  (mosi)
  );

  assign q  = q_q;
  assign cs = cs_q;

endmodule

// File: tb/tb_divmmc_spi.sv
// Bench for divmmc_spi: two instances (DIV=0 and DIV=3) on a shared CPU bus;
// exchanges are scoreboarded, register/pin state checked directly.
module tb_divmmc_spi;

  logic        clock = 1'b0;
  logic        reset0, reset1, ce0, ce1;
  logic        iorq, rd, wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  q0, q1;
  logic        oe0, oe1, busy0, busy1, ck0, ck1, mosi0, mosi1, miso0, miso1;
  logic [1:0]  cs0, cs1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [7:0] tx;
    logic [7:0] rx;
    int         len;
    bit         abort;
  } exp_t;
  exp_t sb[$];

  logic [7:0] pat [2];
  logic [7:0] mb [2];
  logic [7:0] cap [2];
  int         len_c [2];
  int         rises [2];
  logic [1:0] busy_p = 2'b00;
  logic [1:0] ck_p = 2'b00;
  logic [1:0] busy_v, ck_v, mosi_v;
  logic [7:0] q_v [2];

  assign busy_v = {busy1, busy0};
  assign ck_v   = {ck1, ck0};
  assign mosi_v = {mosi1, mosi0};
  assign q_v[0] = q0;
  assign q_v[1] = q1;
  assign miso0  = mb[0][7];
  assign miso1  = mb[1][7];

  always #5 clock = ~clock;

  divmmc_spi #(.DIV(0)) dut0 (
    .clock(clock), .reset(reset0), .ce(ce0), .iorq(iorq), .rd(rd), .wr(wr),
    .a(a), .d(d), .q(q0), .oe(oe0), .busy(busy0), .cs(cs0), .ck(ck0),
    .mosi(mosi0), .miso(miso0)
  );

  divmmc_spi #(.DIV(3)) dut3 (
    .clock(clock), .reset(reset1), .ce(ce1), .iorq(iorq), .rd(rd), .wr(wr),
    .a(a), .d(d), .q(q1), .oe(oe1), .busy(busy1), .cs(cs1), .ck(ck1),
    .mosi(mosi1), .miso(miso1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] tx, input logic [7:0] rx,
                      input int len, input bit abort);
    exp_t e;
    e.k = k; e.tx = tx; e.rx = rx; e.len = len; e.abort = abort;
    sb.push_back(e);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    a = {8'h00, port}; d = data; iorq = 1'b0; wr = 1'b0;
    @(negedge clock);
    iorq = 1'b1; wr = 1'b1;
    @(negedge clock);
  endtask

  task automatic io_read(input int k, input logic [7:0] exp_q);
    a = 16'h00EB; iorq = 1'b0; rd = 1'b0;
    @(negedge clock);
    check("read_oe", {31'd0, (k == 0) ? oe0 : oe1}, 32'd1);
    check("read_q", {24'd0, q_v[k]}, {24'd0, exp_q});
    iorq = 1'b1; rd = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while (busy_v[k] && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check("busy_timeout", 32'd1, 32'd0);
    @(negedge clock);
  endtask

  // Monitor: miso model, mosi capture, length and pulse counting, scoreboard pop.
  initial begin
    exp_t e;
    mb[0] = 8'hFF; mb[1] = 8'hFF;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (busy_v[k] && !busy_p[k]) begin
          len_c[k] = 0; rises[k] = 0; cap[k] = 8'h00; mb[k] = pat[k];
        end
        if (busy_v[k]) len_c[k]++;
        if (ck_v[k] && !ck_p[k]) begin
          rises[k]++;
          cap[k] = {cap[k][6:0], mosi_v[k]};
          mb[k]  = {mb[k][6:0], 1'b1};
        end
        if (!busy_v[k] && busy_p[k]) begin
          if (sb.size() == 0) begin
            check("unexpected_exchange", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("sb_dut", k, e.k);
            if (!e.abort) begin
              check("sb_q", {24'd0, q_v[k]}, {24'd0, e.rx});
              check("sb_mosi", {24'd0, cap[k]}, {24'd0, e.tx});
              check("sb_pulses", rises[k], 32'd8);
              check("sb_busy_len", len_c[k], e.len);
            end
          end
        end
        busy_p[k] = busy_v[k];
        ck_p[k]   = ck_v[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b1; reset1 = 1'b1; ce0 = 1'b1; ce1 = 1'b0;
    iorq = 1'b1; rd = 1'b1; wr = 1'b1; a = 16'h0000; d = 8'h00;
    pat[0] = 8'hFF; pat[1] = 8'hFF;
    repeat (3) @(negedge clock);
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clock);
    check("rst_cs", {30'd0, cs0}, 32'd3);
    check("rst_ck", {31'd0, ck0}, 32'd0);
    check("rst_mosi", {31'd0, mosi0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_q", {24'd0, q0}, 32'hFF);

    // First read: presents FF and kicks off an FF exchange.
    pat[0] = 8'h81;
    push(0, 8'hFF, 8'h81, 16, 1'b0);
    io_read(0, 8'hFF);
    wait_idle(0, 100);

    // CS write held for 5 ce with data changing: written exactly once.
    a = 16'h00E7; d = 8'h02; iorq = 1'b0; wr = 1'b0;
    @(negedge clock);
    check("cs_write", {30'd0, cs0}, 32'd2);
    d = 8'h01;
    repeat (4) @(negedge clock);
    check("cs_once", {30'd0, cs0}, 32'd2);
    iorq = 1'b1; wr = 1'b1;
    @(negedge clock);

    // A5 out, card answers 3C.
    pat[0] = 8'h3C;
    push(0, 8'hA5, 8'h3C, 16, 1'b0);
    io_write(8'hEB, 8'hA5);
    wait_idle(0, 100);
    check("idle_mosi", {31'd0, mosi0}, 32'd1);
    check("idle_ck", {31'd0, ck0}, 32'd0);

    // Reads return previous byte and trigger FF exchanges.
    pat[0] = 8'h5A;
    push(0, 8'hFF, 8'h5A, 16, 1'b0);
    io_read(0, 8'h3C);
    wait_idle(0, 100);
    pat[0] = 8'h00;
    push(0, 8'hFF, 8'h00, 16, 1'b0);
    io_read(0, 8'h5A);
    wait_idle(0, 100);

    // Data write while busy is dropped; CS write while busy lands.
    pat[0] = 8'hC3;
    push(0, 8'h77, 8'hC3, 16, 1'b0);
    io_write(8'hEB, 8'h77);
    io_write(8'hEB, 8'h12);
    io_write(8'hE7, 8'h01);
    check("cs_while_busy", {30'd0, cs0}, 32'd1);
    check("still_busy", {31'd0, busy0}, 32'd1);
    wait_idle(0, 100);
    repeat (20) @(negedge clock);
    check("no_second_exchange", {31'd0, busy0}, 32'd0);

    // DIV=3 instance.
    ce0 = 1'b0; ce1 = 1'b1;
    @(negedge clock);
    io_write(8'hE7, 8'h00);
    check("cs3_write", {30'd0, cs1}, 32'd0);
    pat[1] = 8'h96;
    push(1, 8'hC3, 8'h96, 64, 1'b0);
    io_write(8'hEB, 8'hC3);
    wait_idle(1, 300);

    // ce freeze of 10 clocks mid-transfer stretches busy by 10.
    pat[1] = 8'hE1;
    push(1, 8'h4B, 8'hE1, 74, 1'b0);
    io_write(8'hEB, 8'h4B);
    repeat (20) @(negedge clock);
    ce1 = 1'b0;
    repeat (10) @(negedge clock);
    ce1 = 1'b1;
    wait_idle(1, 300);

    // Reset during bit 4 aborts at once.
    pat[1] = 8'hFF;
    push(1, 8'h0F, 8'h00, 0, 1'b1);
    io_write(8'hEB, 8'h0F);
    repeat (34) @(negedge clock);
    check("busy_before_abort", {31'd0, busy1}, 32'd1);
    reset1 = 1'b1;
    #1;
    check("abort_ck", {31'd0, ck1}, 32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_q", {24'd0, q1}, 32'hFF);
    check("abort_cs", {30'd0, cs1}, 32'd3);
    check("abort_mosi", {31'd0, mosi1}, 32'd1);
    repeat (2) @(negedge clock);
    reset1 = 1'b0;
    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
